// File: rtl/bus_gate_arbiter.sv
// Round-robin gate arbiter for the four shared-bus drivers (PC, MDR, ALU, MARMUX).
// Define BUS_ARB_TIMEOUT_EN to force release after MAX_HOLD cycles while another source waits.
module bus_gate_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] req,
  output logic [3:0] gate,
  output logic       grant_valid,
  output logic [1:0] owner,
  output logic       timeout
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StOwn  = 2'd1;
  localparam logic [1:0] StGap  = 2'd2;

  logic [1:0] state_q, state_d;
  logic [3:0] gate_q, gate_d;
  logic       grant_valid_q;
  logic [1:0] owner_q, owner_d;
  logic [1:0] ptr_q, ptr_d;
  logic       timeout_q, timeout_d;

  logic       rr_found;
  logic [1:0] rr_idx;
  logic [1:0] rr_cand;

  // First set request at or after ptr+1, wrapping; ptr itself is checked last.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = ptr_q;
    rr_cand  = ptr_q;
    for (int i = 1; i <= 4; i++) begin
      rr_cand = ptr_q + 2'(i);
      if (!rr_found && req[rr_cand]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand;
      end
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int unsigned     HoldW   = $clog2(MAX_HOLD + 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(MAX_HOLD);

  logic [HoldW-1:0] hold_q, hold_d;
  logic             others_waiting;

  assign others_waiting = |(req & ~(4'b0001 << owner_q));
`else
  logic unused_max_hold;
  assign unused_max_hold = ^MAX_HOLD;
`endif

  always_comb begin
    state_d   = state_q;
    gate_d    = gate_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    timeout_d = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
    hold_d    = hold_q;
`endif
    case (state_q)
      StOwn: begin
        // A voluntary drop takes precedence over a simultaneous forced release.
        if (!req[owner_q]) begin
          state_d = StGap;
          gate_d  = 4'b0000;
`ifdef BUS_ARB_TIMEOUT_EN
        end else if (hold_q == HoldMax && others_waiting) begin
          state_d   = StGap;
          gate_d    = 4'b0000;
          timeout_d = 1'b1;
        end else if (hold_q != HoldMax) begin
          hold_d = hold_q + HoldW'(1);
`endif
        end
      end
      default: begin
        // IDLE and GAP both arbitrate; GAP falls back to IDLE when nothing is pending.
        if (rr_found) begin
          state_d = StOwn;
          gate_d  = 4'b0001 << rr_idx;
          owner_d = rr_idx;
          ptr_d   = rr_idx;
`ifdef BUS_ARB_TIMEOUT_EN
          hold_d  = HoldW'(1);
`endif
        end else begin
          state_d = StIdle;
          gate_d  = 4'b0000;
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q       <= StIdle;
      gate_q        <= 4'b0000;
      grant_valid_q <= 1'b0;
      owner_q       <= 2'd0;
      ptr_q         <= 2'd3;
      timeout_q     <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      hold_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      gate_q        <= gate_d;
      grant_valid_q <= |gate_d;
      owner_q       <= owner_d;
      ptr_q         <= ptr_d;
      timeout_q     <= timeout_d;
`ifdef BUS_ARB_TIMEOUT_EN
      hold_q        <= hold_d;
`endif
    end
  end

  assign gate        = gate_q;
  assign grant_valid = grant_valid_q;
  assign owner       = owner_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_bus_gate_arbiter.sv
// Self-checking bench for bus_gate_arbiter: directed literal vectors plus a per-cycle
// comparison against an ownership-level model (honours BUS_ARB_TIMEOUT_EN if defined).
module tb_bus_gate_arbiter;

  localparam int unsigned MaxHold = 3;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] gate;
  logic       grant_valid;
  logic [1:0] owner;
  logic       timeout;

  bus_gate_arbiter #(.MAX_HOLD(MaxHold)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .req         (req),
    .gate        (gate),
    .grant_valid (grant_valid),
    .owner       (owner),
    .timeout     (timeout)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: who owns the bus (-1 = nobody), last winner, and arbitration pointer.
  int m_own  = -1;
  int m_last = 0;
  int m_ptr  = 3;
  int m_held = 0;
  bit m_to   = 1'b0;

  function automatic int rr_pick(input int last, input logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  always @(posedge Clk) begin
    int w;
    m_to = 1'b0;
    if (!Reset) begin
      m_own = -1; m_last = 0; m_ptr = 3; m_held = 0;
    end else if (m_own >= 0) begin
      if (!req[m_own]) m_own = -1;
`ifdef BUS_ARB_TIMEOUT_EN
      else if (m_held >= MaxHold && (req & ~(4'b0001 << m_own)) != 4'b0000) begin
        m_own = -1;
        m_to  = 1'b1;
      end else m_held++;
`endif
    end else begin
      w = rr_pick(m_ptr, req);
      if (w >= 0) begin
        m_own = w; m_last = w; m_ptr = w; m_held = 1;
      end
    end
  end

  logic [3:0] prev_gate = 4'b0000;

  always @(negedge Clk) begin
    logic [3:0] exp_gate;
    if (chk_en) begin
      exp_gate = (m_own >= 0) ? (4'b0001 << m_own) : 4'b0000;
      chk("model_gate", gate, exp_gate);
      chk("model_grant_valid", grant_valid, (m_own >= 0));
      chk("model_owner", owner, m_last);
      chk("model_timeout", timeout, m_to);
      chk("onehot0", $onehot0(gate), 1);
      chk("gap_between_owners", (gate != 0 && prev_gate != 0 && gate != prev_gate), 0);
      prev_gate = gate;
    end
  end

  task automatic step(input logic [3:0] r);
    req = r;
    @(posedge Clk);
    #1;
  endtask

  logic [3:0] rr_seq [9];

  initial begin
    rr_seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000,
               4'b0001};

    // Reset held for two edges with all requests pending.
    Reset = 1'b0;
    step(4'b1111);
    step(4'b1111);
    chk_en = 1'b1;
    chk("rst_gate", gate, 4'b0000);
    chk("rst_grant_valid", grant_valid, 0);
    chk("rst_owner", owner, 0);
    chk("rst_timeout", timeout, 0);

    Reset = 1'b1;
    step(4'b1111);
    chk("first_grant_pc", gate, rr_seq[0]);
    chk("first_owner", owner, 0);

    // Round-robin: each owner drops for one sample, then reasserts.
    for (int i = 0; i < 4; i++) begin
      step(4'b1111 & ~(4'b0001 << i));
      chk("rr_gap", gate, rr_seq[2*i+1]);
      step(4'b1111);
      chk("rr_next", gate, rr_seq[2*i+2]);
    end

    // Single requester.
    step(4'b0000);
    chk("pc_release_gap", gate, 4'b0000);
    step(4'b0000);
    for (int i = 0; i < 5; i++) begin
      step(4'b0100);
      chk("single_alu", gate, 4'b0100);
    end
    step(4'b0000);
    chk("single_gap", gate, 4'b0000);
    chk("single_gap_timeout", timeout, 0);
    step(4'b0000);
    chk("single_idle", gate, 4'b0000);
    chk("single_idle_owner", owner, 2);

    // Hold limit with two contenders.
    for (int i = 0; i < 3; i++) begin
      step(4'b0011);
      chk("hold_pc", gate, 4'b0001);
    end
`ifdef BUS_ARB_TIMEOUT_EN
    step(4'b0011);
    chk("to_gap_gate", gate, 4'b0000);
    chk("to_gap_pulse", timeout, 1);
    for (int i = 0; i < 3; i++) begin
      step(4'b0011);
      chk("to_mdr", gate, 4'b0010);
      chk("to_pulse_clear", timeout, 0);
    end
`else
    for (int i = 0; i < 4; i++) begin
      step(4'b0011);
      chk("no_to_pc_keeps", gate, 4'b0001);
      chk("no_to_pulse", timeout, 0);
    end
`endif
    step(4'b0000);
    step(4'b0000);

    // Reset in the middle of a MARMUX grant.
    step(4'b1000);
    chk("marmux_grant", gate, 4'b1000);
    Reset = 1'b0;
    step(4'b1000);
    chk("midrst_gate", gate, 4'b0000);
    chk("midrst_owner", owner, 0);
    Reset = 1'b1;
    step(4'b1010);
    chk("post_rst_mdr", gate, 4'b0010);
    chk("post_rst_owner", owner, 1);
    step(4'b0000);
    step(4'b0000);

    // Random traffic with rare resets; the model and invariants check every cycle.
    for (int i = 0; i < 10000; i++) begin
      Reset = ($urandom_range(0, 199) != 0);
      step(4'($urandom_range(0, 15)));
    end
    Reset = 1'b1;
    step(4'b0000);
    @(negedge Clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
